fifo_drain_framer: RTL and testbench

//  Downstream consumer of the 8x32 synchronous FIFO. Pops words via the FIFO's RD/EN/EMPTY interface.

---
 rtl/fifo_drain_pkg.sv | 20 ++
 rtl/drain_skid_buf.sv | 55 +++++
 rtl/fifo_drain_framer.sv | 129 ++++++++++++
 tb/tb_fifo_drain_framer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain framer and its skid buffer.
package fifo_drain_pkg;

   typedef enum logic {
      S_DATA = 1'b0,
      S_CSUM = 1'b1
   } drain_state_t;

   localparam int SKID_DEPTH = 4;
   localparam int DW_DEF     = 32;
   localparam int OCC_W      = 3;
   localparam int PTR_W      = 2;

   // Words held plus the one possibly in flight from the FIFO.
   function automatic logic [3:0] credit_used(input logic [OCC_W-1:0] occ,
                                              input logic             pend);
      return {1'b0, occ} + {3'b000, pend};
   endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Four-entry circular buffer absorbing the FIFO's registered read latency.
// Head word is visible combinationally on dout; push and pop may coincide.
module drain_skid_buf
   import fifo_drain_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             push,
   input  logic [DW-1:0]    din,
   input  logic             pop,
   output logic [DW-1:0]    dout,
   output logic [OCC_W-1:0] occ
);

   logic [DW-1:0]    r_mem [SKID_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign dout = r_mem[r_rd_ptr];
   assign occ  = r_occ;

endmodule

// File: rtl/fifo_drain_framer.sv
// Pops words from a synchronous FIFO and emits fixed-length frames of
// BURST_LEN data words followed by an XOR checksum word tagged last.
module fifo_drain_framer
   import fifo_drain_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int BURST_LEN = 4,
   parameter int FCNT_W    = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DW-1:0]     fifo_data,
   output logic              fifo_rd,
   output logic              fifo_en,
   output logic [DW-1:0]     m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [FCNT_W-1:0] frames_sent,
   output logic              busy
);

   localparam int              WC_W    = $clog2(BURST_LEN + 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(BURST_LEN - 1);

   drain_state_t      r_state;
   drain_state_t      w_state_next;
   logic              r_fifo_en;
   logic              r_rd_pend;
   logic [DW-1:0]     r_csum;
   logic [WC_W-1:0]   r_word_cnt;
   logic [FCNT_W-1:0] r_frames;

   logic [OCC_W-1:0]  w_occ;
   logic [DW-1:0]     w_head;
   logic              w_pop;
   logic              w_credit_ok;
   logic              w_fifo_rd;

   drain_skid_buf #(
      .DW (DW)
   ) u_skid (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .push  (r_rd_pend),
      .din   (fifo_data),
      .pop   (w_pop),
      .dout  (w_head),
      .occ   (w_occ)
   );

   // Count the in-flight word as occupied so the buffer can never overflow.
   assign w_credit_ok = credit_used(w_occ, r_rd_pend) < 4'(SKID_DEPTH);
   assign w_fifo_rd   = r_fifo_en & enable & ~fifo_empty & w_credit_ok;
   assign fifo_rd     = w_fifo_rd;
   assign fifo_en     = r_fifo_en;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_fifo_en <= 1'b0;
         r_rd_pend <= 1'b0;
      end else begin
         r_fifo_en <= 1'b1;
         r_rd_pend <= w_fifo_rd;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= S_DATA;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      m_valid      = 1'b0;
      m_data       = w_head;
      m_last       = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         S_DATA: begin
            m_valid = (w_occ != '0);
            m_data  = w_head;
            if ((w_occ != '0) && m_ready) begin
               w_pop = 1'b1;
               if (r_word_cnt == WC_LAST) begin
                  w_state_next = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            m_valid = 1'b1;
            m_data  = r_csum;
            m_last  = 1'b1;
            if (m_ready) begin
               w_state_next = S_DATA;
            end
         end
         default: begin
            w_state_next = S_DATA;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_csum     <= '0;
         r_word_cnt <= '0;
         r_frames   <= '0;
      end else begin
         if (w_pop) begin
            r_csum     <= r_csum ^ w_head;
            r_word_cnt <= (r_word_cnt == WC_LAST) ? '0 : r_word_cnt + 1'b1;
         end
         if ((r_state == S_CSUM) && m_ready) begin
            r_csum   <= '0;
            r_frames <= r_frames + 1'b1;
         end
      end
   end

   assign frames_sent = r_frames;
   assign busy        = (r_state == S_CSUM) | (r_word_cnt != '0) | (w_occ != '0) | r_rd_pend;

endmodule

// File: tb/tb_fifo_drain_framer.sv
// Directed bench for fifo_drain_framer with a behavioural FIFO and an output
// capture log; each check is an immediate assertion.
module tb_fifo_drain_framer;

   localparam int DW = 32;

   logic          Clk;
   logic          Rst_n;
   logic          enable;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data;
   logic          fifo_rd;
   logic          fifo_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic [15:0]   frames_sent;
   logic          busy;

   fifo_drain_framer #(
      .DW        (DW),
      .BURST_LEN (4),
      .FCNT_W    (16)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .enable      (enable),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_rd     (fifo_rd),
      .fifo_en     (fifo_en),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .frames_sent (frames_sent),
      .busy        (busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural FIFO: registered read, one word per sampled fifo_rd.
   logic [DW-1:0] fmem [256];
   int            push_cnt = 0;
   int            pop_cnt  = 0;
   int            rd_count = 0;

   assign fifo_empty = (push_cnt == pop_cnt);

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pop_cnt   <= push_cnt;
         fifo_data <= '0;
      end else if (fifo_rd && !fifo_empty) begin
         fifo_data <= fmem[pop_cnt[7:0]];
         pop_cnt   <= pop_cnt + 1;
         rd_count  <= rd_count + 1;
      end
   end

   // Output capture log of every accepted stream beat.
   logic [DW-1:0] cap_data [256];
   logic          cap_last [256];
   int            cap_n = 0;

   always @(posedge Clk) begin
      if (Rst_n && m_valid && m_ready) begin
         cap_data[cap_n[7:0]] <= m_data;
         cap_last[cap_n[7:0]] <= m_last;
         cap_n                <= cap_n + 1;
      end
   end

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fmem[push_cnt[7:0]] = w;
      push_cnt = push_cnt + 1;
   endtask

   task automatic wait_caps(input int target, input string tag);
      for (int i = 0; i < 300; i++) begin
         if (cap_n >= target) break;
         @(negedge Clk);
      end
      chk(tag, 64'(cap_n >= target), 64'd1);
   endtask

   task automatic chk_beat(input int idx, input logic [DW-1:0] d, input logic l, input string tag);
      chk({tag, "_data"}, 64'(cap_data[idx[7:0]]), 64'(d));
      chk({tag, "_last"}, 64'(cap_last[idx[7:0]]), 64'(l));
   endtask

   logic [DW-1:0] exp_w [10];
   logic          exp_l [10];
   int            base;
   int            rd_base;

   initial begin
      Rst_n   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b0;

      // T1 reset
      #2;
      chk("t1_fifo_en", 64'(fifo_en), 64'd0);
      chk("t1_fifo_rd", 64'(fifo_rd), 64'd0);
      chk("t1_m_valid", 64'(m_valid), 64'd0);
      chk("t1_m_data", 64'(m_data), 64'd0);
      chk("t1_m_last", 64'(m_last), 64'd0);
      chk("t1_frames", 64'(frames_sent), 64'd0);
      chk("t1_busy", 64'(busy), 64'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      chk("t1_en_before_edge", 64'(fifo_en), 64'd0);
      @(negedge Clk);
      chk("t1_en_after_edge", 64'(fifo_en), 64'd1);
      chk("t1_rd_empty", 64'(fifo_rd), 64'd0);
      $display("T1 reset: fifo_en=%0d fifo_rd=%0d", fifo_en, fifo_rd);

      // T2 single frame
      base    = cap_n;
      rd_base = rd_count;
      m_ready = 1'b1;
      push_word(32'h11111111);
      push_word(32'h22222222);
      push_word(32'h44444444);
      push_word(32'h88888888);
      wait_caps(base + 5, "t2_timeout");
      repeat (2) @(negedge Clk);
      chk_beat(base + 0, 32'h11111111, 1'b0, "t2_w0");
      chk_beat(base + 1, 32'h22222222, 1'b0, "t2_w1");
      chk_beat(base + 2, 32'h44444444, 1'b0, "t2_w2");
      chk_beat(base + 3, 32'h88888888, 1'b0, "t2_w3");
      chk_beat(base + 4, 32'hFFFFFFFF, 1'b1, "t2_csum");
      chk("t2_frames", 64'(frames_sent), 64'd1);
      chk("t2_rd_cycles", 64'(rd_count - rd_base), 64'd4);
      chk("t2_beats", 64'(cap_n - base), 64'd5);
      chk("t2_busy", 64'(busy), 64'd0);
      $display("T2 frame: beats=%0d frames_sent=%0d rd=%0d", cap_n - base, frames_sent, rd_count - rd_base);

      // T3 backpressure
      base    = cap_n;
      rd_base = rd_count;
      m_ready = 1'b0;
      exp_w[0] = 32'hA0000001; exp_w[1] = 32'h0B000002;
      exp_w[2] = 32'h00C00004; exp_w[3] = 32'h000D0008;
      exp_w[4] = 32'hABCD000F;
      exp_w[5] = 32'h12345678; exp_w[6] = 32'h87654321;
      exp_w[7] = 32'hFFFF0000; exp_w[8] = 32'h0000FFFF;
      exp_w[9] = 32'h6AAEEAA6;
      for (int i = 0; i < 10; i++) exp_l[i] = (i == 4) || (i == 9);
      for (int i = 0; i < 10; i++) begin
         if (!exp_l[i]) push_word(exp_w[i]);
      end
      repeat (10) @(negedge Clk);
      chk("t3_rd_stalled", 64'(rd_count - rd_base), 64'd4);
      chk("t3_fifo_rd_low", 64'(fifo_rd), 64'd0);
      chk("t3_valid_held", 64'(m_valid), 64'd1);
      chk("t3_data_held_a", 64'(m_data), 64'(exp_w[0]));
      repeat (3) @(negedge Clk);
      chk("t3_data_held_b", 64'(m_data), 64'(exp_w[0]));
      chk("t3_last_held", 64'(m_last), 64'd0);
      m_ready = 1'b1;
      wait_caps(base + 10, "t3_timeout");
      repeat (2) @(negedge Clk);
      for (int i = 0; i < 10; i++) begin
         chk_beat(base + i, exp_w[i], exp_l[i], $sformatf("t3_beat%0d", i));
      end
      chk("t3_beats", 64'(cap_n - base), 64'd10);
      chk("t3_rd_total", 64'(rd_count - rd_base), 64'd8);
      chk("t3_frames", 64'(frames_sent), 64'd3);
      $display("T3 backpressure: beats=%0d frames_sent=%0d", cap_n - base, frames_sent);

      // T4 underflow mid-frame
      base = cap_n;
      push_word(32'h00000100);
      push_word(32'h00000200);
      wait_caps(base + 2, "t4_timeout_a");
      repeat (3) @(negedge Clk);
      chk("t4_valid_gap", 64'(m_valid), 64'd0);
      chk("t4_busy_gap", 64'(busy), 64'd1);
      chk("t4_beats_gap", 64'(cap_n - base), 64'd2);
      push_word(32'h00000400);
      push_word(32'h00000800);
      wait_caps(base + 5, "t4_timeout_b");
      repeat (2) @(negedge Clk);
      chk_beat(base + 2, 32'h00000400, 1'b0, "t4_w2");
      chk_beat(base + 3, 32'h00000800, 1'b0, "t4_w3");
      chk_beat(base + 4, 32'h00000F00, 1'b1, "t4_csum");
      chk("t4_frames", 64'(frames_sent), 64'd4);
      $display("T4 underflow: csum=%0h frames_sent=%0d", cap_data[(base + 4) % 256], frames_sent);

      // T5 enable dropped after three pops
      base    = cap_n;
      rd_base = rd_count;
      push_word(32'h01010101);
      push_word(32'h02020202);
      push_word(32'h04040404);
      push_word(32'h08080808);
      for (int i = 0; i < 50; i++) begin
         if (rd_count - rd_base >= 3) break;
         @(negedge Clk);
      end
      chk("t5_three_pops", 64'(rd_count - rd_base), 64'd3);
      enable = 1'b0;
      #1;
      chk("t5_rd_drops", 64'(fifo_rd), 64'd0);
      repeat (8) @(negedge Clk);
      chk("t5_no_more_rd", 64'(rd_count - rd_base), 64'd3);
      chk("t5_busy", 64'(busy), 64'd1);
      chk("t5_beats_partial", 64'(cap_n - base), 64'd3);
      chk("t5_no_csum", 64'(frames_sent), 64'd4);
      enable = 1'b1;
      wait_caps(base + 5, "t5_timeout");
      repeat (2) @(negedge Clk);
      chk_beat(base + 3, 32'h08080808, 1'b0, "t5_w3");
      chk_beat(base + 4, 32'h0F0F0F0F, 1'b1, "t5_csum");
      chk("t5_frames", 64'(frames_sent), 64'd5);
      $display("T5 enable gap: rd=%0d frames_sent=%0d", rd_count - rd_base, frames_sent);

      // T6 asynchronous reset with a partial frame held
      m_ready = 1'b0;
      push_word(32'hDEAD0000);
      push_word(32'h0000BEEF);
      push_word(32'h5A5A5A5A);
      repeat (6) @(negedge Clk);
      chk("t6_pre_valid", 64'(m_valid), 64'd1);
      chk("t6_pre_busy", 64'(busy), 64'd1);
      @(posedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      chk("t6_valid_async", 64'(m_valid), 64'd0);
      chk("t6_frames_async", 64'(frames_sent), 64'd0);
      chk("t6_busy_async", 64'(busy), 64'd0);
      chk("t6_en_async", 64'(fifo_en), 64'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      base    = cap_n;
      m_ready = 1'b1;
      push_word(32'h00000003);
      push_word(32'h00000005);
      push_word(32'h00000009);
      push_word(32'h00000011);
      wait_caps(base + 5, "t6_timeout");
      repeat (2) @(negedge Clk);
      chk_beat(base + 0, 32'h00000003, 1'b0, "t6_w0");
      chk_beat(base + 3, 32'h00000011, 1'b0, "t6_w3");
      chk_beat(base + 4, 32'h0000001E, 1'b1, "t6_csum");
      chk("t6_frames", 64'(frames_sent), 64'd1);
      chk("t6_busy_end", 64'(busy), 64'd0);
      $display("T6 async reset: csum=%0h frames_sent=%0d", cap_data[(base + 4) % 256], frames_sent);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
